// File: rtl/encoder_frontend.sv
// rtl/encoder_frontend.sv - quadrature encoder conditioning and x4 decoder
// Optional glitch filter enabled by macro QENC_GLITCH_FILTER_EN.
module encoder_frontend #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic encoder_a,
   input  logic encoder_b,
   input  logic err_clr,
   output logic a_filt,
   output logic b_filt,
   output logic step,
   output logic dir,
   output logic err,
   output logic err_flag
);

`ifdef QENC_GLITCH_FILTER_EN
   localparam int SETTLE = FILTER_LEN + 3;
`else
   // FILTER_LEN has no effect without the filter
   localparam int SETTLE = 3 + 0 * FILTER_LEN;
`endif
   localparam logic [8:0] SETTLE_CNT = 9'(SETTLE);

   typedef enum logic {INIT, RUN} state_t;

   logic [1:0] meta;
   logic [1:0] s;
   logic [1:0] filt;
   logic [1:0] prev;
   logic [8:0] settle_cnt;
   state_t     state_q;
   state_t     state_d;
   logic       step_d;
   logic       err_d;
   logic       dir_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 2'b00;
         s    <= 2'b00;
      end else begin
         meta <= {encoder_a, encoder_b};
         s    <= meta;
      end
   end

`ifdef QENC_GLITCH_FILTER_EN
   localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);
   logic [7:0] cnt [2];

   // a new level is accepted on the FILTER_LEN-th consecutive differing sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt <= 2'b00;
         for (int i = 0; i < 2; i++) cnt[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (s[i] == filt[i]) begin
               cnt[i] <= 8'd0;
            end else if (cnt[i] == CNT_LAST) begin
               filt[i] <= s[i];
               cnt[i]  <= 8'd0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) filt <= 2'b00;
      else       filt <= s;
   end
`endif

   assign a_filt = filt[1];
   assign b_filt = filt[0];

   always_comb begin
      state_d = state_q;
      step_d  = 1'b0;
      err_d   = 1'b0;
      dir_d   = dir;
      case (state_q)
         INIT: if (settle_cnt == SETTLE_CNT) state_d = RUN;
         RUN: begin
            case (prev ^ filt)
               2'b00: ;
               2'b11: err_d = 1'b1;
               default: begin
                  step_d = 1'b1;
                  // forward when new A differs from old B (Gray sequence 00,10,11,01)
                  dir_d  = filt[1] ^ prev[0];
               end
            endcase
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= INIT;
         settle_cnt <= 9'd0;
         prev       <= 2'b00;
         step       <= 1'b0;
         err        <= 1'b0;
         dir        <= 1'b1;
         err_flag   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) settle_cnt <= settle_cnt + 9'd1;
         prev <= filt;
         step <= step_d;
         err  <= err_d;
         dir  <= dir_d;
         // set wins over a clear arriving with or during the err pulse
         err_flag <= err_d | err | (err_flag & ~err_clr);
      end
   end

endmodule

// File: tb/tb_encoder_frontend.sv
// tb/tb_encoder_frontend.sv - self-checking bench for encoder_frontend
module tb_encoder_frontend;
   localparam int FL = 4;
`ifdef QENC_GLITCH_FILTER_EN
   localparam int LAT = 2 + FL;
`else
   localparam int LAT = 3;
`endif

   typedef struct {
      logic a;
      logic b;
      int   kind;   // 0 none, 1 step, 2 err
      logic dir;
      int   hold;
      int   phase;
   } vec_t;

   typedef struct {
      int   cyc;
      logic is_err;
      logic dir;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enc_a = 1'b0;
   logic enc_b = 1'b0;
   logic err_clr = 1'b0;
   logic a_filt, b_filt, step, dir, err, err_flag;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   int   phase = 0;
   int   fwd_cnt = 0;
   int   rev_cnt = 0;
   exp_t sb[$];
   exp_t e_m;
   vec_t vecs[$];

   encoder_frontend #(.FILTER_LEN(FL)) dut (
      .clk(clk), .reset(reset), .encoder_a(enc_a), .encoder_b(enc_b),
      .err_clr(err_clr), .a_filt(a_filt), .b_filt(b_filt), .step(step),
      .dir(dir), .err(err), .err_flag(err_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int expv);
      n_vec++;
      if (got != expv) begin
         n_miss++;
         $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, expv, cyc);
      end
   endtask

   // entered just after a rising edge; leaves just after a rising edge
   task automatic drive(input logic na, input logic nb, input int kind,
                        input logic edir, input int hold);
      exp_t e;
      enc_a = na;
      enc_b = nb;
      if (kind != 0) begin
         e.cyc = cyc + LAT + 1;
         e.is_err = (kind == 2);
         e.dir = edir;
         sb.push_back(e);
      end
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic add(input logic a, input logic b, input int kind,
                      input logic d, input int hold, input int ph);
      vec_t v;
      v.a = a; v.b = b; v.kind = kind; v.dir = d; v.hold = hold; v.phase = ph;
      vecs.push_back(v);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         n_vec++;
         n_miss++;
         $display("FAIL missed_pulse got=none exp_cyc=%0d err=%0b dir=%0b", sb[0].cyc, sb[0].is_err, sb[0].dir);
         e_m = sb.pop_front();
      end
      if (step || err) begin
         if (step && phase == 1) fwd_cnt++;
         if (step && phase == 2) rev_cnt++;
         n_vec++;
         if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_pulse got step=%0b err=%0b dir=%0b cyc=%0d exp=none", step, err, dir, cyc);
         end else begin
            e_m = sb.pop_front();
            if (cyc != e_m.cyc || err != e_m.is_err || step == e_m.is_err || dir != e_m.dir) begin
               n_miss++;
               $display("FAIL pulse got cyc=%0d step=%0b err=%0b dir=%0b exp cyc=%0d err=%0b dir=%0b",
                        cyc, step, err, dir, e_m.cyc, e_m.is_err, e_m.dir);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 30; i++) begin
         add(1, 0, 1, 1, 10, 1); add(1, 1, 1, 1, 10, 1);
         add(0, 1, 1, 1, 10, 1); add(0, 0, 1, 1, 10, 1);
      end
      for (int i = 0; i < 25; i++) begin
         add(0, 1, 1, 0, 10, 2); add(1, 1, 1, 0, 10, 2);
         add(1, 0, 1, 0, 10, 2); add(0, 0, 1, 0, 10, 2);
      end
`ifdef QENC_GLITCH_FILTER_EN
      add(1, 0, 0, 0, 3, 3);  add(0, 0, 0, 0, 12, 3);
`else
      add(1, 0, 1, 1, 3, 3);  add(0, 0, 1, 0, 12, 3);
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_filt", a_filt, 0);
      chk("rst_b_filt", b_filt, 0);
      chk("rst_step", step, 0);
      chk("rst_err", err, 0);
      chk("rst_err_flag", err_flag, 0);
      chk("rst_dir", dir, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         phase = vecs[i].phase;
         drive(vecs[i].a, vecs[i].b, vecs[i].kind, vecs[i].dir, vecs[i].hold);
      end
      chk("fwd_step_count", fwd_cnt, 120);
      chk("rev_step_count", rev_cnt, 100);

      // filtered-level latency on a long pulse
      drive(1, 0, 1, 1, 0);
      repeat (LAT) @(negedge clk);
      chk("a_filt_before_lat", a_filt, 0);
      @(negedge clk);
      chk("a_filt_at_lat", a_filt, 1);
      @(posedge clk); #1;
      drive(0, 0, 1, 0, 10);

      // illegal double change, clear, and clear coinciding with err
      drive(1, 1, 2, 0, 10);
      @(negedge clk);
      chk("err_flag_set", err_flag, 1);
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_flag_cleared", err_flag, 0);
      @(posedge clk); #1;
      drive(0, 0, 2, 0, 0);
      repeat (LAT + 1) @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(negedge clk);
      chk("err_with_clr", err, 1);
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_flag_set_wins", err_flag, 1);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 5);

      // reset mid-filter discards the partial count
      enc_a = 1'b1;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("midrst_a_filt", a_filt, 0);
      chk("midrst_err_flag", err_flag, 0);
      chk("midrst_dir", dir, 1);
      chk("midrst_step", step, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("midrst_a_after", a_filt, 1);
      chk("midrst_b_after", b_filt, 0);

      // release with inputs already at 11: INIT must absorb it
      reset = 1'b1;
      enc_a = 1'b1;
      enc_b = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      chk("init11_pair", {a_filt, b_filt}, 3);
      chk("init11_err_flag", err_flag, 0);
      drive(0, 1, 1, 1, 10);

      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/encoder_frontend.md
ENCODER_FRONTEND -- requirements
Module: encoder_frontend

Interface
REQ-001 Parameter FILTER_LEN, default 4, cycles a synchronized input must hold a new level before acceptance; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 encoder_a  input  1  raw quadrature channel A, asynchronous to clk.
REQ-005 encoder_b  input  1  raw quadrature channel B, asynchronous to clk.
REQ-006 err_clr  input  1  synchronous clear of err_flag; one-cycle pulse.
REQ-007 a_filt  output  1  conditioned channel A.
REQ-008 b_filt  output  1  conditioned channel B.
REQ-009 step  output  1  one-cycle pulse per legal quadrature edge (x4 decoding).
REQ-010 dir  output  1  direction of the latest legal edge; 1 = forward (A leads B), 0 = reverse.
REQ-011 err  output  1  one-cycle pulse on an illegal transition.
REQ-012 err_flag  output  1  sticky error indicator.

Function
REQ-013 Each channel SHALL pass through a 2-flop synchronizer; synchronized pair s = {sa, sb}.
REQ-014 Per-channel filter: counter cleared when s equals filtered level; incremented while they differ; filtered level takes s and counter clears on the FILTER_LEN-th consecutive mismatching sample.
REQ-015 Latency raw edge -> a_filt/b_filt SHALL be 2 + FILTER_LEN cycles (filter compiled in); a glitch shorter than FILTER_LEN synchronized samples SHALL never reach a_filt/b_filt.
REQ-016 Decoder SHALL register prev = {a_filt, b_filt} and compare with current pair every cycle in RUN.
REQ-017 Forward sequence SHALL be 00->10->11->01->00 ({a,b}); each such change -> step=1, dir=1 one cycle after the filtered change.
REQ-018 Reverse sequence 00->01->11->10->00 -> step=1, dir=0, same latency.
REQ-019 Both bits changing in one cycle (00<->11, 10<->01) -> err=1, step=0, dir unchanged, err_flag set; prev still updates.
REQ-020 No change -> step=0, err=0, dir held.
REQ-021 FSM states INIT, RUN; INIT after reset, counts SETTLE = FILTER_LEN + 3 cycles (3 without filter), then loads prev from current filtered pair and enters RUN; no step/err in INIT.
REQ-022 RUN -> INIT only via reset.
REQ-023 err_flag cleared by err_clr; if err and err_clr coincide, err_flag SHALL end set (set wins).
REQ-024 step and err SHALL never both be 1 in one cycle.

Reset
REQ-025 On reset assertion, immediately: synchronizers, filter counters, a_filt, b_filt, prev = 0; step, err, err_flag = 0; dir = 1; FSM = INIT.
REQ-026 Reset mid-sequence SHALL discard partial filter counts; first pulse after release only after INIT completes.

Configuration
REQ-027 Macro QENC_GLITCH_FILTER_EN: defined -> filter per REQ-014/015 present and FILTER_LEN used.
REQ-028 Not defined -> a_filt/b_filt = synchronized s registered once (latency 3 cycles), FILTER_LEN ignored, SETTLE = 3; decoding identical.

Verification (FILTER_LEN=4, macro defined unless stated)
REQ-029 Reset, inputs 00, then 30 forward cycles (A rise, B rise, A fall, B fall, 10 clk apart) -> 120 step pulses, dir=1 throughout, err never 1.
REQ-030 25 reverse cycles (B leads) -> 100 step pulses, dir=0 from the first pulse on, err never 1.
REQ-031 encoder_a high for 3 clk then low while stable otherwise -> a_filt stays 0, no step; high for 4+ clk -> a_filt=1 exactly 6 cycles after raw edge, step 1 cycle later.
REQ-032 Inputs 00 -> 11 same cycle in RUN -> err pulse, err_flag=1, step=0; err_clr pulse -> err_flag=0 next cycle; err+err_clr same cycle -> err_flag=1.
REQ-033 Reset released with inputs held 11 -> no err and no step during or after INIT; next legal edge 11->01 -> step=1, dir=1.
REQ-034 Macro undefined: 3-clk pulse on encoder_a -> passes to a_filt after 3 cycles and produces step pulses (forward then reverse).
